// File: rtl/quiz3_a_pkg.sv
// ---------------------------------------------------------------------------
// quiz3_a_pkg
// Shared constants and types for the quiz3_a three-input function block.
//
// Contents:
//   DEFAULT_TRUTH_TABLE : 8'hCA, i.e. F = x&y | ~x&z (minterms 1,3,6,7)
//   DEFAULT_CNT_W       : default width of the F-high cycle counter
//   NUM_IDX             : number of distinct input combinations
//   idx_t               : 3-bit input index {x,y,z}
//   idx_onehot()        : one-hot mask for an input index
// ---------------------------------------------------------------------------
package quiz3_a_pkg;

   localparam logic [7:0] DEFAULT_TRUTH_TABLE = 8'hCA;
   localparam int         DEFAULT_CNT_W       = 8;
   localparam int         NUM_IDX             = 8;

   typedef logic [2:0] idx_t;

   // An unknown index shifts to an unknown mask, so X on an input
   // shows up in the statistics instead of being silently hidden.
   function automatic logic [NUM_IDX-1:0] idx_onehot(input idx_t idx);
      return {{(NUM_IDX-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/quiz3_a_lut.sv
// ---------------------------------------------------------------------------
// quiz3_a_lut
// Purely combinational 8-entry table lookup: f = TRUTH_TABLE[idx].
//
// Parameters:
//   TRUTH_TABLE : bit i is the function value for input index i
// Ports:
//   idx : input  3-bit input index {x,y,z}
//   f   : output function value (zero latency, propagates X on idx)
// ---------------------------------------------------------------------------
module quiz3_a_lut
   import quiz3_a_pkg::*;
#(
   parameter logic [7:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE
)(
   input  idx_t idx,
   output logic f
);

   // A plain bit-select keeps X on the index visible as X on the result.
   assign f = TRUTH_TABLE[idx];

endmodule

// File: rtl/quiz3_a.sv
// ---------------------------------------------------------------------------
// quiz3_a
// Three-input Boolean function with a registered copy and optional usage
// statistics.
//
// Parameters:
//   TRUTH_TABLE : bit i is F for input index i = {x,y,z} (default 8'hCA)
//   CNT_W       : width of the F-high cycle counter (default 8)
// Ports (declaration order is fixed so quiz3_a u(F, x, y, z) is valid):
//   F       : output combinational function result, valid during reset
//   x, y, z : input  function inputs, x is the MSB of the index
//   clk     : input  rising-edge clock
//   rst_n   : input  asynchronous active-low reset
//   f_q     : output F registered one cycle
//   seen    : output bit i set once index i has been sampled
//   f_count : output saturating count of edges that sampled F=1
// Configuration:
//   QUIZ3_A_STATS_EN : when defined, seen and f_count are live; when
//                      undefined they are tied to zero and no statistics
//                      registers exist.
// ---------------------------------------------------------------------------
module quiz3_a
   import quiz3_a_pkg::*;
#(
   parameter logic [7:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
   parameter int         CNT_W       = DEFAULT_CNT_W
)(
   output logic             F,
   input  logic             x,
   input  logic             y,
   input  logic             z,
   input  logic             clk,
   input  logic             rst_n,
   output logic             f_q,
   output logic [7:0]       seen,
   output logic [CNT_W-1:0] f_count
);

   idx_t idx;
   logic run_en;

   assign idx = {x, y, z};

   quiz3_a_lut #(
      .TRUTH_TABLE (TRUTH_TABLE)
   ) u_lut (
      .idx (idx),
      .f   (F)
   );

   // Reset release is taken up by this flop on the first edge after rst_n
   // rises; registers only start updating on the edge after that, so no
   // register ever sees a reset deassertion that is close to its own edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_en <= 1'b0;
      end else begin
         run_en <= 1'b1;
      end
   end

   // Registered copy of the function output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q <= 1'b0;
      end else if (run_en) begin
         f_q <= F;
      end
   end

`ifdef QUIZ3_A_STATS_EN

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [7:0]       seen_r;
   logic [CNT_W-1:0] f_count_r;

   // Sticky record of every input index sampled since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_r <= 8'h00;
      end else if (run_en) begin
         seen_r <= seen_r | idx_onehot(idx);
      end
   end

   // Count edges that sampled F=1, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_count_r <= '0;
      end else if (run_en && F && (f_count_r != CNT_MAX)) begin
         f_count_r <= f_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign seen    = seen_r;
   assign f_count = f_count_r;

`else

   assign seen    = 8'h00;
   assign f_count = '0;

`endif

endmodule

// File: tb/tb_quiz3_a.sv
// ---------------------------------------------------------------------------
// tb_quiz3_a
// Directed self-checking bench for quiz3_a. Two instances share the inputs:
// one with the default table (8'hCA) and one with the odd-parity table
// (8'h96). Expected values are hand-computed constants; statistics
// expectations collapse to zero when QUIZ3_A_STATS_EN is undefined.
// ---------------------------------------------------------------------------
module tb_quiz3_a;

`ifdef QUIZ3_A_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // Hand-computed function values for index 0..7.
   localparam logic [0:7] F_A = 8'b0101_0011;   // x&y | ~x&z
   localparam logic [0:7] F_B = 8'b0110_1001;   // odd parity

   logic       clk;
   logic       rst_n;
   logic       x, y, z;

   logic       f_a, fq_a;
   logic [7:0] seen_a;
   logic [7:0] cnt_a;

   logic       f_b, fq_b;
   logic [7:0] seen_b;
   logic [7:0] cnt_b;

   int total;
   int bad;

   quiz3_a dut (
      .F       (f_a),
      .x       (x),
      .y       (y),
      .z       (z),
      .clk     (clk),
      .rst_n   (rst_n),
      .f_q     (fq_a),
      .seen    (seen_a),
      .f_count (cnt_a)
   );

   quiz3_a #(
      .TRUTH_TABLE (8'h96),
      .CNT_W       (8)
   ) dut_par (
      .F       (f_b),
      .x       (x),
      .y       (y),
      .z       (z),
      .clk     (clk),
      .rst_n   (rst_n),
      .f_q     (fq_b),
      .seen    (seen_b),
      .f_count (cnt_b)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic [2:0] idx);
      {x, y, z} = idx;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] stat(input logic [31:0] v);
      return STATS ? v : 32'd0;
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      applyStimulus(3'd0);

      // Combinational sweep with reset held: F must follow the table.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(3'(i));
         #100;
         checkOutput($sformatf("F_A_idx%0d", i), 32'(f_a), 32'(F_A[i]));
         checkOutput($sformatf("F_B_idx%0d", i), 32'(f_b), 32'(F_B[i]));
      end
      checkOutput("rst_fq",   32'(fq_a),  32'd0);
      checkOutput("rst_seen", 32'(seen_a), 32'd0);
      checkOutput("rst_cnt",  32'(cnt_a),  32'd0);

      // Release: first edge only arms the enable, second edge updates.
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(3'd7);
      @(negedge clk);
      checkOutput("arm_fq",   32'(fq_a),  32'd0);
      checkOutput("arm_cnt",  32'(cnt_a),  32'd0);
      @(negedge clk);
      checkOutput("first_fq",   32'(fq_a),   32'd1);
      checkOutput("first_cnt",  32'(cnt_a),  stat(32'd1));
      checkOutput("first_seen", 32'(seen_a), stat(32'h80));

      // Hold index 7 (F=1 in both tables) long enough to saturate.
      repeat (300) @(negedge clk);
      checkOutput("sat_cnt_a", 32'(cnt_a), stat(32'd255));
      checkOutput("sat_cnt_b", 32'(cnt_b), stat(32'd255));
      repeat (5) @(negedge clk);
      checkOutput("sat_hold", 32'(cnt_a), stat(32'd255));
      checkOutput("sat_fq",   32'(fq_a),  32'd1);

      // Fresh reset, then a clocked sweep: f_q follows F one cycle later.
      rst_n = 1'b0;
      #1;
      checkOutput("rst2_cnt", 32'(cnt_a), 32'd0);
      applyStimulus(3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(3'(i));
         @(negedge clk);
         checkOutput($sformatf("sweep_F_%0d", i),  32'(f_a),  32'(F_A[i]));
         checkOutput($sformatf("sweep_fq_%0d", i), 32'(fq_a), 32'(F_A[i]));
         checkOutput($sformatf("sweep_fqb_%0d", i), 32'(fq_b), 32'(F_B[i]));
      end
      checkOutput("sweep_seen_a", 32'(seen_a), stat(32'hFF));
      checkOutput("sweep_seen_b", 32'(seen_b), stat(32'hFF));
      checkOutput("sweep_cnt_a",  32'(cnt_a),  stat(32'd4));
      checkOutput("sweep_cnt_b",  32'(cnt_b),  stat(32'd4));

      // Reset pulse between edges: registers clear at once, F unaffected.
      applyStimulus(3'd6);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("pulse_fq",   32'(fq_a),   32'd0);
      checkOutput("pulse_seen", 32'(seen_a), 32'd0);
      checkOutput("pulse_cnt",  32'(cnt_a),  32'd0);
      checkOutput("pulse_F",    32'(f_a),    32'd1);
      checkOutput("pulse_Fb",   32'(f_b),    32'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("pulse_arm_fq", 32'(fq_a), 32'd0);
      @(negedge clk);
      checkOutput("pulse_upd_fq",   32'(fq_a),   32'd1);
      checkOutput("pulse_upd_seen", 32'(seen_a), stat(32'h40));
      checkOutput("pulse_upd_cnt",  32'(cnt_a),  stat(32'd1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
